// File: rtl/bar_handshake_rr_arbiter.sv
// Round-robin arbiter sharing one ready/valid channel among N requesters,
// with optional burst locking and a single registered output stage.
module bar_handshake_rr_arbiter #(
    parameter int N         = 3,
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 2,
    localparam int GW       = $clog2(N)
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESETN,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*WIDTH-1:0]   req_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [GW-1:0]        out_grant,
    output logic                 locked
);

    localparam int BW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]   owner_q, owner_d;
    logic [BW-1:0]   burst_q, burst_d;

    logic            load_en;
    logic            xfer;
    logic [GW-1:0]   scan_start;
    logic [GW-1:0]   winner;
    logic            winner_found;
    logic [WIDTH-1:0] sel_data;

    // Increment modulo N; N need not be a power of two.
    function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] idx);
        if (idx == GW'(N - 1)) begin
            return '0;
        end
        return idx + GW'(1);
    endfunction

    // A locked owner that still has data wins outright; otherwise scan round-robin,
    // starting just past the owner when a lock is being released early.
    always_comb begin
        scan_start   = (state_q == LOCKED) ? next_idx(owner_q) : rr_ptr_q;
        winner       = '0;
        winner_found = 1'b0;
        if (state_q == LOCKED && req_valid[owner_q]) begin
            winner       = owner_q;
            winner_found = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!winner_found && req_valid[(int'(scan_start) + k) % N]) begin
                    winner       = GW'((int'(scan_start) + k) % N);
                    winner_found = 1'b1;
                end
            end
        end
    end

    assign load_en  = !out_valid || out_ready;
    assign xfer     = load_en && winner_found;
    assign sel_data = req_data[int'(winner)*WIDTH +: WIDTH];

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            burst_q  <= burst_d;
        end
    end

    // Arbitration state only advances when the output stage can accept a beat.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        burst_d  = burst_q;
        if (load_en) begin
            case (state_q)
                IDLE: begin
                    if (winner_found) begin
                        if (MAX_BURST == 1) begin
                            rr_ptr_d = next_idx(winner);
                        end else begin
                            owner_d = winner;
                            burst_d = BW'(1);
                            state_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (req_valid[owner_q]) begin
                        if (burst_q + BW'(1) == BW'(MAX_BURST)) begin
                            rr_ptr_d = next_idx(owner_q);
                            burst_d  = '0;
                            state_d  = IDLE;
                        end else begin
                            burst_d = burst_q + BW'(1);
                        end
                    end else if (winner_found) begin
                        owner_d = winner;
                        burst_d = BW'(1);
                    end else begin
                        rr_ptr_d = next_idx(owner_q);
                        burst_d  = '0;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Ready is forced low while reset is held so nothing is accepted then.
    always_comb begin
        req_ready = '0;
        if (ASYNCRESETN && load_en && winner_found) begin
            req_ready = N'(1) << winner;
        end
        locked = (state_q == LOCKED);
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_grant <= '0;
        end else if (load_en) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data  <= sel_data;
                out_grant <= winner;
            end
        end
    end

endmodule

// File: tb/tb_bar_handshake_rr_arbiter.sv
// Directed bench: one arbiter with MAX_BURST=1 and one with MAX_BURST=2 share the stimulus;
// a vector table plus hand sequences cover round robin, bursts, release, stalls and reset.
module tb_bar_handshake_rr_arbiter;

    localparam int N     = 3;
    localparam int WIDTH = 4;
    localparam int GW    = 2;

    logic                CLK = 1'b0;
    logic                ASYNCRESETN = 1'b0;
    logic [N-1:0]        req_valid = '0;
    logic [N*WIDTH-1:0]  req_data = '0;
    logic                out_ready = 1'b0;

    logic [N-1:0]        rr_ready;
    logic                rr_ov;
    logic [WIDTH-1:0]    rr_data;
    logic [GW-1:0]       rr_grant;
    logic                rr_locked;

    logic [N-1:0]        b_ready;
    logic                b_ov;
    logic [WIDTH-1:0]    b_data;
    logic [GW-1:0]       b_grant;
    logic                b_locked;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0]       valid;
        logic [N*WIDTH-1:0] data;
        logic               oready;
        logic [N-1:0]       exp_ready;
        logic               exp_ov;
        logic [GW-1:0]      exp_grant;
        logic [WIDTH-1:0]   exp_data;
        logic               exp_locked;
    } vec_t;

    vec_t vecs[$];

    bar_handshake_rr_arbiter #(.N(N), .WIDTH(WIDTH), .MAX_BURST(1)) dut_rr (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
        .req_valid(req_valid), .req_ready(rr_ready), .req_data(req_data),
        .out_valid(rr_ov), .out_ready(out_ready), .out_data(rr_data),
        .out_grant(rr_grant), .locked(rr_locked)
    );

    bar_handshake_rr_arbiter #(.N(N), .WIDTH(WIDTH), .MAX_BURST(2)) dut_b (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
        .req_valid(req_valid), .req_ready(b_ready), .req_data(req_data),
        .out_valid(b_ov), .out_ready(out_ready), .out_data(b_data),
        .out_grant(b_grant), .locked(b_locked)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic add_vec(input logic [N-1:0] v, input logic [N*WIDTH-1:0] d, input logic r,
                           input logic [N-1:0] er, input logic eov, input logic [GW-1:0] eg,
                           input logic [WIDTH-1:0] ed, input logic el);
        vec_t t;
        t.valid = v; t.data = d; t.oready = r;
        t.exp_ready = er; t.exp_ov = eov; t.exp_grant = eg; t.exp_data = ed; t.exp_locked = el;
        vecs.push_back(t);
    endtask

    // Drive one vector just after an edge, check ready before the next edge, outputs after it.
    task automatic applyStimulus(input vec_t v, input int idx);
        req_valid = v.valid;
        req_data  = v.data;
        out_ready = v.oready;
        #1;
        checkOutput($sformatf("row%0d req_ready", idx), int'(b_ready), int'(v.exp_ready));
        @(posedge CLK);
        #1;
        checkOutput($sformatf("row%0d out_valid", idx), int'(b_ov), int'(v.exp_ov));
        checkOutput($sformatf("row%0d out_grant", idx), int'(b_grant), int'(v.exp_grant));
        checkOutput($sformatf("row%0d out_data", idx), int'(b_data), int'(v.exp_data));
        checkOutput($sformatf("row%0d locked", idx), int'(b_locked), int'(v.exp_locked));
    endtask

    task automatic do_reset();
        ASYNCRESETN = 1'b0;
        req_valid   = '1;
        req_data    = 12'hCBA;
        out_ready   = 1'b1;
        #1;
        checkOutput("reset ready b", int'(b_ready), 0);
        checkOutput("reset ready rr", int'(rr_ready), 0);
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset out_valid b", int'(b_ov), 0);
        checkOutput("reset locked b", int'(b_locked), 0);
        checkOutput("reset ready b held", int'(b_ready), 0);
        ASYNCRESETN = 1'b1;
        req_valid   = '0;
    endtask

    // Protocol monitor: ready is one-hot-or-zero, and a stalled beat must not change.
    logic             mon_ok = 1'b0;
    logic             stall_b = 1'b0, stall_r = 1'b0;
    logic [WIDTH-1:0] prev_data_b = '0, prev_data_r = '0;
    logic [GW-1:0]    prev_grant_b = '0, prev_grant_r = '0;

    always @(negedge CLK) begin
        checkOutput("onehot0 ready b", int'($onehot0(b_ready)), 1);
        checkOutput("onehot0 ready rr", int'($onehot0(rr_ready)), 1);
        if (mon_ok && ASYNCRESETN) begin
            if (stall_b) begin
                checkOutput("stall data b", int'(b_data), int'(prev_data_b));
                checkOutput("stall grant b", int'(b_grant), int'(prev_grant_b));
            end
            if (stall_r) begin
                checkOutput("stall data rr", int'(rr_data), int'(prev_data_r));
                checkOutput("stall grant rr", int'(rr_grant), int'(prev_grant_r));
            end
        end
        mon_ok       = ASYNCRESETN;
        stall_b      = b_ov && !out_ready;
        stall_r      = rr_ov && !out_ready;
        prev_data_b  = b_data;
        prev_grant_b = b_grant;
        prev_data_r  = rr_data;
        prev_grant_r = rr_grant;
    end

    initial begin
        // valid  data     ordy  ready  ov grant data locked
        add_vec(3'b111, 12'hCBA, 1'b1, 3'b001, 1'b1, 2'd0, 4'hA, 1'b1);
        add_vec(3'b111, 12'hCBA, 1'b1, 3'b001, 1'b1, 2'd0, 4'hA, 1'b0);
        add_vec(3'b111, 12'hCBA, 1'b1, 3'b010, 1'b1, 2'd1, 4'hB, 1'b1);
        add_vec(3'b111, 12'hCBA, 1'b1, 3'b010, 1'b1, 2'd1, 4'hB, 1'b0);
        add_vec(3'b111, 12'hCBA, 1'b1, 3'b100, 1'b1, 2'd2, 4'hC, 1'b1);
        add_vec(3'b111, 12'hCBA, 1'b1, 3'b100, 1'b1, 2'd2, 4'hC, 1'b0);
        add_vec(3'b111, 12'hCBA, 1'b1, 3'b001, 1'b1, 2'd0, 4'hA, 1'b1);
        add_vec(3'b010, 12'hCBA, 1'b1, 3'b010, 1'b1, 2'd1, 4'hB, 1'b1);
        add_vec(3'b100, 12'h5BA, 1'b1, 3'b100, 1'b1, 2'd2, 4'h5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            add_vec(3'b100, 12'h6BA, 1'b0, 3'b000, 1'b1, 2'd2, 4'h5, 1'b1);
        end
        add_vec(3'b100, 12'h6BA, 1'b1, 3'b100, 1'b1, 2'd2, 4'h6, 1'b0);
        add_vec(3'b111, 12'hCBA, 1'b1, 3'b001, 1'b1, 2'd0, 4'hA, 1'b1);
        add_vec(3'b000, 12'hCBA, 1'b1, 3'b000, 1'b0, 2'd0, 4'hA, 1'b0);
        add_vec(3'b000, 12'hCBA, 1'b1, 3'b000, 1'b0, 2'd0, 4'hA, 1'b0);
        add_vec(3'b110, 12'hCBA, 1'b1, 3'b010, 1'b1, 2'd1, 4'hB, 1'b1);
        add_vec(3'b110, 12'hCBA, 1'b0, 3'b000, 1'b1, 2'd1, 4'hB, 1'b1);

        // Idle after reset
        do_reset();
        out_ready = 1'b1;
        repeat (5) begin
            @(posedge CLK);
            #1;
            checkOutput("idle out_valid b", int'(b_ov), 0);
            checkOutput("idle out_valid rr", int'(rr_ov), 0);
            checkOutput("idle ready b", int'(b_ready), 0);
        end
        checkOutput("idle out_data b", int'(b_data), 0);
        checkOutput("idle locked b", int'(b_locked), 0);

        // Plain round robin on the MAX_BURST=1 instance
        do_reset();
        req_valid = 3'b111;
        req_data  = 12'hCBA;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            checkOutput($sformatf("rr%0d ready", k), int'(rr_ready), 1 << (k % 3));
            @(posedge CLK);
            #1;
            checkOutput($sformatf("rr%0d out_valid", k), int'(rr_ov), 1);
            checkOutput($sformatf("rr%0d grant", k), int'(rr_grant), k % 3);
            checkOutput($sformatf("rr%0d data", k), int'(rr_data), 10 + (k % 3));
            checkOutput($sformatf("rr%0d locked", k), int'(rr_locked), 0);
        end

        // Burst, early release, backpressure and no-request vectors on the MAX_BURST=2 instance
        do_reset();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i], i);
        end

        // Asynchronous reset in the middle of a burst
        do_reset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs[i], 100 + i);
        end
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        checkOutput("midrst out_valid", int'(b_ov), 0);
        checkOutput("midrst locked", int'(b_locked), 0);
        checkOutput("midrst ready", int'(b_ready), 0);
        checkOutput("midrst out_data", int'(b_data), 0);
        checkOutput("midrst out_grant", int'(b_grant), 0);
        #3;
        ASYNCRESETN = 1'b1;
        #1;
        checkOutput("postrst ready", int'(b_ready), 1);
        @(posedge CLK);
        #1;
        checkOutput("postrst out_valid", int'(b_ov), 1);
        checkOutput("postrst grant", int'(b_grant), 0);
        checkOutput("postrst data", int'(b_data), 10);
        checkOutput("postrst locked", int'(b_locked), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
